// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit.
//   - Request opcode encodings carried on req_op.
//   - FSM state encoding, also exported on the unit's debug state port.
package mau_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between the CPU datapath and the
// memory access unit.
//   master : CPU side   - drives req_valid/op/addr/data and resp_ready
//   slave  : unit side  - drives req_ready and resp_valid/data/err
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. Once valid is raised, the payload stays
// stable until that transfer; ready may depend on state but never on valid.
interface mem_access_unit_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = $clog2(WIDTH)
);

    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WIDTH-1:0]      req_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [WIDTH-1:0]      resp_data;
    logic                  resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/mau_wdata_sel.sv
// Selects the value written back to memory for a modifying request.
//   op        : latched request opcode
//   mem_odata : current entry value from memory
//   data_q    : latched request operand
//   wdata     : ADD -> mem_odata + data_q (carry dropped), else data_q
module mau_wdata_sel
    import mau_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] mem_odata,
    input  logic [WIDTH-1:0] data_q,
    output logic [WIDTH-1:0] wdata
);

    always_comb begin
        wdata = data_q;
        if (op == OP_ADD) begin
            wdata = mem_odata + data_q;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Sequencer in front of the 8-entry register memory. Accepts one
// LOAD/STORE/ADD/SWAP request at a time, reads the entry, optionally writes
// it back one cycle later, and returns the pre-operation value.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : request/response handshake (slave modport)
//   mem_write   : memory write enable, one cycle in WRITE only
//   mem_addr    : memory address (always the latched request address)
//   mem_idata   : memory write data
//   mem_odata   : memory combinational read data
//   dbg_state   : current FSM state
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = $clog2(WIDTH),
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_access_unit_if.slave      bus,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_idata,
    input  logic [WIDTH-1:0]      mem_odata,
    output state_t                dbg_state
);

    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];

    state_t                state_q, state_d;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      data_q;
    logic                  err_q;
    logic [WIDTH-1:0]      rdata_q;
    logic [WIDTH-1:0]      wdata_q;
    logic [WIDTH-1:0]      wdata;
    logic                  read_only;

    mau_wdata_sel #(.WIDTH(WIDTH)) u_wdata_sel (
        .op        (op_q),
        .mem_odata (mem_odata),
        .data_q    (data_q),
        .wdata     (wdata)
    );

    // Out-of-range requests skip the write so they can never alias an entry.
    assign read_only = (op_q == OP_LOAD) || err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake and write strobes are gated with rst so they drop in the
    // reset cycle itself, including a reset that lands on WRITE.
    always_comb begin
        state_d       = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        mem_write      = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = read_only ? RESP : WRITE;
            end
            WRITE: begin
                mem_write = !rst && !err_q;
                state_d   = RESP;
            end
            RESP: begin
                bus.resp_valid = !rst;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_LOAD;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q   <= bus.req_op;
                        addr_q <= bus.req_addr;
                        data_q <= bus.req_data;
                        err_q  <= ({1'b0, bus.req_addr} >= DEPTH_L);
                    end
                end
                READ: begin
                    rdata_q <= err_q ? '0 : mem_odata;
                    if (!read_only) begin
                        wdata_q <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr      = addr_q;
    assign mem_idata     = wdata_q;
    assign bus.resp_data = rdata_q;
    assign bus.resp_err  = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and short random checks of mem_access_unit against a behavioural
// 8-entry memory and a reference copy of its contents.
module tb_mem_access_unit;
    import mau_pkg::*;

    localparam int WIDTH      = 32;
    localparam int ADDR_WIDTH = $clog2(WIDTH);
    localparam int DEPTH      = 8;

    logic                  clk;
    logic                  rst;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_idata;
    logic [WIDTH-1:0]      mem_odata;
    state_t                dbg_state;

    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH:0]   exp_q[$];   // {err, data}

    int n_assert;
    int n_fail;

    mem_access_unit_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    mem_access_unit #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_idata (mem_idata),
        .mem_odata (mem_odata),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: combinational read, write at the edge, same reset
    assign mem_odata = (mem_addr < DEPTH) ? mem[mem_addr[2:0]] : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_write && mem_addr < DEPTH) begin
            mem[mem_addr[2:0]] <= mem_idata;
        end
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: issue one request, check latency, write activity, response
    task automatic do_op(input logic [1:0] op, input logic [ADDR_WIDTH-1:0] addr,
                         input logic [WIDTH-1:0] data, input int hold);
        logic             in_range;
        logic [WIDTH-1:0] old, exp_wd, wd, rd;
        logic [WIDTH:0]   exp;
        logic [ADDR_WIDTH-1:0] wa;
        int               exp_lat, exp_wr, lat, wr_cnt;
        logic             got;

        in_range = (addr < DEPTH);
        old      = in_range ? ref_mem[addr[2:0]] : '0;
        exp_q.push_back({!in_range, old});
        exp_wd   = (op == OP_ADD) ? old + data : data;
        exp_wr   = (in_range && op != OP_LOAD) ? 1 : 0;
        exp_lat  = (exp_wr == 1) ? 3 : 2;
        if (exp_wr == 1) ref_mem[addr[2:0]] = exp_wd;

        @(negedge clk);
        chk("req_ready_idle", {31'd0, bus.req_ready}, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_data  = $urandom;

        lat = 0; wr_cnt = 0; got = 1'b0; wa = '0; wd = '0;
        while (lat < 8 && !got) begin
            @(negedge clk);
            lat++;
            if (mem_write) begin
                wr_cnt++;
                wa = mem_addr;
                wd = mem_idata;
            end
            if (bus.resp_valid) got = 1'b1;
        end

        chk("write_count", wr_cnt, exp_wr);
        if (exp_wr == 1) begin
            chk("write_addr", {27'd0, wa}, {27'd0, addr});
            chk("write_data", wd, exp_wd);
        end

        if (!got) begin
            chk("resp_timeout", 0, 1);
            void'(exp_q.pop_front());
        end else begin
            chk("resp_latency", lat, exp_lat);
            exp = exp_q.pop_front();
            chk("resp_data", bus.resp_data, exp[WIDTH-1:0]);
            chk("resp_err", {31'd0, bus.resp_err}, {31'd0, exp[WIDTH]});
            rd = bus.resp_data;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_valid", {31'd0, bus.resp_valid}, 1);
                chk("hold_data", bus.resp_data, rd);
                chk("hold_req_ready", {31'd0, bus.req_ready}, 0);
            end
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.resp_ready = 1'b0;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = OP_LOAD;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 0);
        chk("rst_mem_write", {31'd0, mem_write}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", {31'd0, bus.req_ready}, 1);
        chk("post_rst_resp_valid", {31'd0, bus.resp_valid}, 0);
        chk("post_rst_resp_data", bus.resp_data, 0);
        chk("post_rst_resp_err", {31'd0, bus.resp_err}, 0);
        chk("post_rst_mem_addr", {27'd0, mem_addr}, 0);
        chk("post_rst_mem_idata", mem_idata, 0);

        // 1: load from reset memory
        do_op(OP_LOAD, 5'd3, 32'h0, 0);
        // 2: store then load
        do_op(OP_STORE, 5'd5, 32'hDEADBEEF, 0);
        do_op(OP_LOAD, 5'd5, 32'h0, 0);
        // 3: add with wrap
        do_op(OP_STORE, 5'd2, 32'hFFFFFFFF, 0);
        do_op(OP_ADD, 5'd2, 32'h00000002, 0);
        do_op(OP_LOAD, 5'd2, 32'h0, 0);
        // 4: swap
        do_op(OP_STORE, 5'd7, 32'h00000011, 0);
        do_op(OP_SWAP, 5'd7, 32'h00000022, 0);
        do_op(OP_LOAD, 5'd7, 32'h0, 0);
        // 5: out of range, no aliasing onto entry 1
        do_op(OP_STORE, 5'd9, 32'h12345678, 0);
        do_op(OP_LOAD, 5'd1, 32'h0, 0);
        // 6a: consumer back-pressure
        do_op(OP_LOAD, 5'd5, 32'h0, 4);

        // 6b: reset landing on the WRITE cycle of a store to entry 4
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_STORE;
        bus.req_addr  = 5'd4;
        bus.req_data  = 32'hCAFEF00D;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);   // READ
        @(negedge clk);   // WRITE
        chk("pre_rst_state", {30'd0, dbg_state}, {30'd0, WRITE});
        chk("pre_rst_mem_write", {31'd0, mem_write}, 1);
        rst = 1'b1;
        #1;
        chk("rst_write_mem_write", {31'd0, mem_write}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(negedge clk);
        chk("abort_req_ready", {31'd0, bus.req_ready}, 1);
        chk("abort_resp_valid", {31'd0, bus.resp_valid}, 0);
        chk("abort_state", {30'd0, dbg_state}, {30'd0, IDLE});
        do_op(OP_LOAD, 5'd4, 32'h0, 0);

        // short random mix, addresses include out-of-range ones
        for (int k = 0; k < 12; k++) begin
            do_op(2'($urandom_range(0, 3)), 5'($urandom_range(0, 9)), $urandom, $urandom_range(0, 2));
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_op(OP_LOAD, 5'(i), 32'h0, 0);
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // overall time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end expected end of test");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Sequencer directly upstream of the 8-entry register memory: accepts load/store/read-modify-write requests over a valid/ready handshake and drives the memory's write/addr/idata ports. Captures odata and returns a response over a second valid/ready handshake. Memory read is combinational; a write commits at the clock edge ending the write cycle. Gives the CPU datapath one atomic access port with uniform old-value return.

Parameters:
WIDTH, 32, data width; must match memory WIDTH
ADDR_WIDTH, $clog2(WIDTH), address width; must match memory addr width
DEPTH, 8, number of implemented memory entries; addresses >= DEPTH are out of range

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_op  input  2  00 LOAD, 01 STORE, 10 ADD, 11 SWAP
req_addr  input  ADDR_WIDTH  target entry
req_data  input  WIDTH  store / addend / swap operand
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_data  output  WIDTH  entry value before the operation
resp_err  output  1  address out of range
mem_write  output  1  to memory write
mem_addr  output  ADDR_WIDTH  to memory addr
mem_idata  output  WIDTH  to memory idata
mem_odata  input  WIDTH  from memory odata

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). While rst=1, outputs are forced: req_ready=0, resp_valid=0, mem_write=0. From the first cycle after reset: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_err=0, mem_write=0, mem_addr=0, mem_idata=0.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch op, addr and data. Set err_q = (addr >= DEPTH). Go to READ.
- READ: mem_addr=addr_q, mem_write=0. Register rdata_q = err_q ? 0 : mem_odata.
  - LOAD, or err_q=1: go to RESP.
  - Otherwise register wdata_q and go to WRITE. wdata_q = data_q for STORE/SWAP; mem_odata + data_q for ADD (modulo 2^WIDTH, carry discarded).
- WRITE: mem_write=1 for exactly this cycle, mem_addr=addr_q, mem_idata=wdata_q. Go to RESP.
- RESP: resp_valid=1, resp_data=rdata_q, resp_err=err_q. All three hold stable until resp_ready=1. On the handshake cycle go to IDLE. No new request is accepted in the handshake cycle.
- Latency, with acceptance at cycle T:
  - LOAD or error: resp_valid at T+2.
  - STORE/ADD/SWAP: resp_valid at T+3; memory updated before RESP, so a following LOAD sees the new value.
- Throughput: at most one op per 3 (read-only) or 4 (write) cycles.
- mem_addr outside READ/WRITE: holds addr_q.
- mem_write is never asserted for an out-of-range address, in any state other than WRITE, or while rst=1.
- Reset mid-operation: the op is abandoned with no response. If rst coincides with WRITE, no write occurs. The memory is reset by the same rst.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package mau_pkg: op encodings (OP_LOAD=2'b00, OP_STORE=2'b01, OP_ADD=2'b10, OP_SWAP=2'b11) and FSM state enum (IDLE, READ, WRITE, RESP).
- One sub-module, mau_wdata_sel: combinational; inputs op, mem_odata, data_q; output wdata.
- FSM and registers stay in mem_access_unit.

Test Plan:
1. Reset, then LOAD addr 3 -> resp_valid exactly 2 cycles after acceptance; resp_data=0x00000000, resp_err=0; mem_write never asserted.
2. STORE addr 5 data 0xDEADBEEF -> mem_write high exactly one cycle with mem_addr=5, mem_idata=0xDEADBEEF; resp_data=0x00000000 (old value). Then LOAD 5 -> 0xDEADBEEF.
3. STORE addr 2 0xFFFFFFFF, then ADD addr 2 data 0x00000002 -> resp_data=0xFFFFFFFF. Then LOAD 2 -> 0x00000001 (wrap).
4. STORE addr 7 0x00000011, then SWAP addr 7 data 0x00000022 -> resp_data=0x00000011. Then LOAD 7 -> 0x00000022.
5. STORE addr 9 data 0x12345678 -> no mem_write pulse; resp_err=1, resp_data=0; LOAD 1 still returns 0x00000000 (no aliasing).
6. Hold resp_ready=0 for 4 cycles on a LOAD -> resp_valid/resp_data stable, req_ready=0 throughout. Separately, assert rst during WRITE of a STORE to addr 4 -> mem_write=0 that cycle, no response; first cycle after reset: req_ready=1, resp_valid=0.
